// File: rtl/fmap_buffer.sv
// Feature-map buffer for the dense stage: fills a ROWS x COLS map of (OC+1)-channel
// pixels in raster order, then serves horizontally adjacent pixel pairs until released.
//
// state | meaning
// FILL  | accepting raster-order write beats; dense low
// FULL  | map complete; dense high, writes rejected, reads served
module fmap_buffer #(
  parameter int OC   = 15,
  parameter int ROWS = 14,
  parameter int COLS = 14,
  parameter int DW   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic signed [0:OC][DW-1:0]       wr_data,
  output logic                             dense,
  input  logic [4:0]                       row,
  input  logic [4:0]                       col,
  input  logic                             rd_done,
  output logic signed [0:OC][0:1][DW-1:0]  dataOut,
  output logic                             frame_err
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int VW    = (OC + 1) * DW;

  typedef enum logic {FILL, FULL} state_t;

  state_t             state, state_nxt;
  logic [4:0]         wr_row, wr_col;
  logic               wr_last, wr_en;
  logic [AW-1:0]      wr_addr, rd_addr0, rd_addr1;
  logic               in_rng, pair_ok;
  logic [0:OC][DW-1:0] rd0, rd1;
  logic [VW-1:0]      mem [0:DEPTH-1];

  assign wr_last = (int'(wr_row) == ROWS - 1) && (int'(wr_col) == COLS - 1);
  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    dense     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        wr_en    = wr_valid;
        if (wr_valid && wr_last) state_nxt = FULL;
      end
      FULL: begin
        dense = 1'b1;
        if (rd_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_row    <= '0;
      wr_col    <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FULL && wr_valid) frame_err <= 1'b1;
      if (wr_en) begin
        if (wr_last) begin
          wr_row <= '0;
          wr_col <= '0;
        end else if (int'(wr_col) == COLS - 1) begin
          wr_col <= '0;
          wr_row <= wr_row + 5'd1;
        end else begin
          wr_col <= wr_col + 5'd1;
        end
      end
    end
  end

  // Storage carries no reset; a fresh frame overwrites whatever was left behind.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Out-of-range addresses are forced to zero so the memory is never indexed past DEPTH.
  always_comb begin
    in_rng   = (int'(row) < ROWS) && (int'(col) < COLS);
    pair_ok  = in_rng && (int'(col) + 1 < COLS);
    rd_addr0 = in_rng ? AW'(int'(row) * COLS + int'(col)) : '0;
    rd_addr1 = pair_ok ? rd_addr0 + 1'b1 : '0;
    rd0      = mem[rd_addr0];
    rd1      = mem[rd_addr1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataOut <= '0;
    end else begin
      for (int ch = 0; ch <= OC; ch++) begin
        dataOut[ch][0] <= in_rng  ? rd0[ch] : '0;
        dataOut[ch][1] <= pair_ok ? rd1[ch] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fmap_buffer.sv
// Self-checking bench for fmap_buffer: constant vector table, hand-written corner
// sequences and randomized traffic against a frame-level reference model.
module tb_fmap_buffer;
  localparam int OC = 15, ROWS = 14, COLS = 14, DW = 8, NPIX = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, wr_valid, rd_done, wr_ready, dense, frame_err;
  logic signed [0:OC][DW-1:0] wr_data;
  logic [4:0] row, col;
  logic signed [0:OC][0:1][DW-1:0] dataOut;

  fmap_buffer #(.OC(OC), .ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .dense(dense), .row(row), .col(col), .rd_done(rd_done), .dataOut(dataOut),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: pixel store indexed by raster position, beat count, full/err flags.
  logic [DW-1:0] ref_mem [0:OC][0:NPIX-1];
  bit m_full, m_err;
  int m_cnt;

  typedef struct {int r; int c; int ch; int e0; int e1;} vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [0:OC][0:1][DW-1:0] ref_read(input int r, input int c);
    logic [0:OC][0:1][DW-1:0] v;
    v = '0;
    if (r < ROWS && c < COLS) begin
      for (int ch = 0; ch <= OC; ch++) begin
        v[ch][0] = ref_mem[ch][r * COLS + c];
        if (c + 1 < COLS) v[ch][1] = ref_mem[ch][r * COLS + c + 1];
      end
    end
    return v;
  endfunction

  // One clock: predict from the pre-edge model, advance the model, then compare.
  task automatic cycle();
    logic [0:OC][0:1][DW-1:0] e;
    bit full_pre;
    e = ref_read(int'(row), int'(col));
    full_pre = m_full;
    if (wr_valid && !full_pre) begin
      for (int ch = 0; ch <= OC; ch++) ref_mem[ch][m_cnt] = wr_data[ch];
      m_cnt++;
      if (m_cnt == NPIX) begin
        m_full = 1'b1;
        m_cnt  = 0;
      end
    end else if (wr_valid && full_pre) begin
      m_err = 1'b1;
    end
    if (full_pre && rd_done) m_full = 1'b0;
    @(posedge clk);
    #1;
    chk("dataOut", dataOut, e);
    chk("wr_ready", wr_ready, !m_full);
    chk("dense", dense, m_full);
    chk("frame_err", frame_err, m_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1'b1);
    chk({tag, "_dense"}, dense, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_dataOut"}, dataOut, '0);
  endtask

  initial begin
    logic [DW-1:0] t0, t1;
    int n;

    tbl[0] = '{3, 4, 5, 51, 52};
    tbl[1] = '{13, 13, 0, 67, 0};
    tbl[2] = '{13, 13, 15, 82, 0};
    tbl[3] = '{14, 0, 0, 0, 0};
    tbl[4] = '{0, 13, 2, 15, 0};
    tbl[5] = '{0, 0, 7, 7, 8};
    tbl[6] = '{2, 14, 0, 0, 0};
    tbl[7] = '{13, 12, 3, 69, 70};

    rst = 1'b0; wr_valid = 1'b0; rd_done = 1'b0; row = 5'd14; col = 5'd0; wr_data = '0;
    m_full = 1'b0; m_err = 1'b0; m_cnt = 0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Frame 1: (index + ch) mod 128.
    for (int i = 0; i < NPIX; i++) begin
      wr_valid = 1'b1;
      for (int ch = 0; ch <= OC; ch++) wr_data[ch] = 8'((i + ch) % 128);
      chk("ready_before_beat", wr_ready, 1'b1);
      cycle();
      if (i == NPIX - 2) chk("dense_before_last", dense, 1'b0);
    end
    wr_valid = 1'b0;
    chk("dense_after_last", dense, 1'b1);
    chk("wr_ready_full", wr_ready, 1'b0);

    for (int k = 0; k < 8; k++) begin
      row = 5'(tbl[k].r);
      col = 5'(tbl[k].c);
      cycle();
      t0 = tbl[k].e0[DW-1:0];
      t1 = tbl[k].e1[DW-1:0];
      chk("tbl_slot0", dataOut[tbl[k].ch][0], t0);
      chk("tbl_slot1", dataOut[tbl[k].ch][1], t1);
      if (tbl[k].r >= ROWS || tbl[k].c >= COLS) chk("tbl_oob_all", dataOut, '0);
    end

    // Rejected write in FULL: sticky flag, memory untouched.
    row = 5'd0; col = 5'd0;
    wr_valid = 1'b1;
    wr_data = '1;
    cycle();
    wr_valid = 1'b0;
    chk("frame_err_set", frame_err, 1'b1);
    cycle();
    chk("frame_err_sticky", frame_err, 1'b1);
    for (int ch = 0; ch <= OC; ch++) begin
      t0 = 8'(ch);
      chk("orig_00", dataOut[ch][0], t0);
    end

    // Release with a simultaneous write: write must be ignored.
    rd_done = 1'b1; wr_valid = 1'b1; wr_data = '1;
    cycle();
    rd_done = 1'b0; wr_valid = 1'b0;
    chk("release_dense", dense, 1'b0);
    chk("release_ready", wr_ready, 1'b1);
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
    chk("rd_done_fill_ignored", wr_ready, 1'b1);
    chk("simul_write_ignored", dataOut[3][0], 8'd3);

    // Frame 2: randomized data with gaps, random/colliding reads, stray rd_done.
    n = 0;
    while (n < NPIX) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch <= OC; ch++)
        wr_data[ch] = (n == 0) ? -8'sd5 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        row = 5'(m_cnt / COLS);
        col = 5'(m_cnt % COLS);
      end else begin
        row = 5'($urandom_range(0, 15));
        col = 5'($urandom_range(0, 15));
      end
      rd_done = ($urandom_range(0, 7) == 0);
      if (wr_valid) n++;
      cycle();
    end
    wr_valid = 1'b0; rd_done = 1'b0;
    chk("frame2_dense", dense, 1'b1);
    for (int k = 0; k < 60; k++) begin
      row = 5'($urandom_range(0, 15));
      col = 5'($urandom_range(0, 15));
      cycle();
    end
    row = 5'd0; col = 5'd0;
    cycle();
    chk("frame2_neg", dataOut[0][0], 8'hFB);

    // Reset part-way through a fill.
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
    row = 5'd14;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1;
      for (int ch = 0; ch <= OC; ch++) wr_data[ch] = 8'((i + ch + 7) % 128);
      cycle();
    end
    wr_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk_reset_outputs("midfill_reset");
    m_full = 1'b0; m_err = 1'b0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      wr_valid = 1'b1;
      for (int ch = 0; ch <= OC; ch++) wr_data[ch] = 8'((i + ch + 7) % 128);
      cycle();
      if (i == 95) chk("dense_not_at_96", dense, 1'b0);
    end
    wr_valid = 1'b0;
    chk("dense_after_refill", dense, 1'b1);
    row = 5'd13; col = 5'd13;
    cycle();
    chk("refill_last_px", dataOut[1][0], 8'((195 + 1 + 7) % 128));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
